// File: rtl/image_downsample.sv
// image_downsample: grabs one camera frame on request, averages every 16x16
// block of a square capture window (GRID blocks per side; 28 -> 448x448,
// 784 results) and streams the 8-bit block values to image_mem in row-major
// order.
module image_downsample #(
  parameter int FRAME_W = 640,
  parameter int X_START = 96,
  parameter int Y_START = 16,
  parameter bit INVERT  = 1'b1,
  parameter int GRID    = 28
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        capture,
  input  logic        sof,
  input  logic        pix_vld,
  input  logic [11:0] pix_gray,
  output logic        mem_we,
  output logic [9:0]  mem_waddr,
  output logic [7:0]  mem_wdata,
  output logic        busy,
  output logic        done
);

  localparam int         WIN       = GRID * 16;
  localparam int         BW        = (GRID > 1) ? $clog2(GRID) : 1;
  localparam logic [9:0] LAST_ADDR = 10'(GRID * GRID - 1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [11:0]   x;
  logic [11:0]   y;
  logic [11:0]   rx;
  logic [11:0]   ry;
  logic [BW-1:0] bx;
  logic [15:0]   acc [GRID];
  logic [15:0]   sum;
  logic [7:0]    avg;
  logic [9:0]    addr_nxt;     // address the next completed block goes to
  logic          in_win;
  logic          take;         // pixel accepted by the capture datapath
  logic          blk_done;     // this pixel closes a 16x16 block
  logic          unused_bits;

  // Window-relative coordinates and block bookkeeping for the current pixel.
  assign rx       = x - 12'(X_START);
  assign ry       = y - 12'(Y_START);
  assign bx       = rx[4 +: BW];
  assign in_win   = (x >= 12'(X_START)) && (x < 12'(X_START + WIN)) &&
                    (y >= 12'(Y_START)) && (y < 12'(Y_START + WIN));
  // Nothing is accepted once the final write has gone out (done cycle).
  assign take     = (state == CAPTURE) && pix_vld && !sof && !done;
  assign blk_done = take && in_win && (rx[3:0] == 4'hF) && (ry[3:0] == 4'hF);
  assign sum      = acc[bx] + {8'd0, pix_gray[11:4]};
  assign avg      = sum[15:8];
  assign busy     = (state != IDLE);

  // Low pixel bits and high coordinate bits carry no information here.
  assign unused_bits = ^{pix_gray[3:0], rx[11:4+BW], ry[11:4]};

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: arm on capture, start on sof, finish after last write.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    case (state)
      IDLE:    if (capture) state_nxt = ARMED;
      ARMED:   if (sof)     state_nxt = CAPTURE;
      CAPTURE: if (done)    state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // Raster position: x counts valid pixels, y counts wrapped lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (sof) begin
      x <= '0;
      y <= '0;
    end else if (state == CAPTURE && pix_vld) begin
      if (x == 12'(FRAME_W - 1)) begin
        x <= '0;
        y <= y + 12'd1;
      end else begin
        x <= x + 12'd1;
      end
    end
  end

  // Per-column-block accumulators; a block's sum is dropped once written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the accumulator array is reset explicitly because a reset
      // mid-frame must not leak partial sums into the next capture.
      for (int i = 0; i < GRID; i++) acc[i] <= '0;
    end else if (sof) begin
      for (int i = 0; i < GRID; i++) acc[i] <= '0;
    end else if (take && in_win) begin
      acc[bx] <= blk_done ? 16'd0 : sum;
    end
  end

  // Registered write port, address sequencing and completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      addr_nxt  <= '0;
    end else begin
      mem_we <= blk_done;
      done   <= blk_done && (addr_nxt == LAST_ADDR);
      if (sof && state != IDLE) begin
        mem_waddr <= '0;
        addr_nxt  <= '0;
      end else if (blk_done) begin
        mem_waddr <= addr_nxt;
        mem_wdata <= INVERT ? (8'd255 - avg) : avg;
        addr_nxt  <= addr_nxt + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_image_downsample.sv
// tb_image_downsample: drives small frames into two image_downsample copies
// (inverted and plain output) and compares their write streams with block
// averages computed directly from the stimulus image.
module tb_image_downsample;

  localparam int W   = 148;
  localparam int H   = 66;
  localparam int XS  = 96;
  localparam int YS  = 16;
  localparam int G   = 3;
  localparam int WIN = G * 16;
  localparam int NW  = G * G;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] data;
    logic       done;
    int         cyc;
  } wr_t;

  typedef struct {
    int addr;
    int d1;
    int d0;
    bit done;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        capture;
  logic        sof;
  logic        pix_vld;
  logic [11:0] pix_gray;
  logic        we1, we0, busy1, busy0, done1, done0;
  logic [9:0]  waddr1, waddr0;
  logic [7:0]  wdata1, wdata0;

  logic [11:0] img [H][W];
  wr_t         wr1_q[$];
  wr_t         wr0_q[$];
  exp_t        exp_q[$];
  int          stamp_q[$];
  int          cyc;
  int          done1_cnt;
  int          done0_cnt;
  int          busy_err;
  logic        prev_done;
  logic        prev_busy;
  int          first_blk_cyc;
  logic        armed_busy;
  int          n_assert;
  int          n_fail;

  image_downsample #(.FRAME_W(W), .X_START(XS), .Y_START(YS), .INVERT(1'b1), .GRID(G)) dut_inv (
    .clk(clk), .rst_n(rst_n), .capture(capture), .sof(sof), .pix_vld(pix_vld),
    .pix_gray(pix_gray), .mem_we(we1), .mem_waddr(waddr1), .mem_wdata(wdata1),
    .busy(busy1), .done(done1));

  image_downsample #(.FRAME_W(W), .X_START(XS), .Y_START(YS), .INVERT(1'b0), .GRID(G)) dut_raw (
    .clk(clk), .rst_n(rst_n), .capture(capture), .sof(sof), .pix_vld(pix_vld),
    .pix_gray(pix_gray), .mem_we(we0), .mem_waddr(waddr0), .mem_wdata(wdata0),
    .busy(busy0), .done(done0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (we1) wr1_q.push_back('{waddr1, wdata1, done1, cyc});
    if (we0) wr0_q.push_back('{waddr0, wdata0, done0, cyc});
    if (done1) done1_cnt <= done1_cnt + 1;
    if (done0) done0_cnt <= done0_cnt + 1;
    if ((prev_done && busy1) || (done1 && !busy1) ||
        (prev_busy && !busy1 && !prev_done && rst_n) || (busy1 !== busy0))
      busy_err <= busy_err + 1;
    prev_done <= done1;
    prev_busy <= busy1;
  end

  // Reference: mean of the 256 8-bit samples of one block, truncated.
  function automatic int block_avg(input int bx, input int by);
    int s;
    s = 0;
    for (int j = 0; j < 16; j++)
      for (int i = 0; i < 16; i++)
        s += int'(img[YS + 16*by + j][XS + 16*bx + i][11:4]);
    return s / 256;
  endfunction

  // Expected writes for a capture that saw frame rows 0..nrows-1.
  task automatic model_segment(input int nrows, input bit full);
    int a;
    for (int by = 0; by < G; by++) begin
      if (YS + 16*by + 15 < nrows) begin
        for (int bx = 0; bx < G; bx++) begin
          a = block_avg(bx, by);
          exp_q.push_back('{by*G + bx, 255 - a, a, full && (by == G-1) && (bx == G-1)});
        end
      end
    end
  endtask

  // Scoreboard walk: counts expected entries not matched by both DUTs.
  function automatic int score(input int b1, input int b0, input int bs, output string first);
    int bad;
    bad = 0;
    first = "";
    for (int i = 0; i < exp_q.size(); i++) begin
      if (b1 + i >= wr1_q.size() || b0 + i >= wr0_q.size() || bs + i >= stamp_q.size()) begin
        bad++;
        if (first == "") first = $sformatf("entry %0d absent", i);
      end else if (32'(wr1_q[b1+i].addr) !== exp_q[i].addr || 32'(wr0_q[b0+i].addr) !== exp_q[i].addr ||
                   wr1_q[b1+i].data !== 8'(exp_q[i].d1) || wr0_q[b0+i].data !== 8'(exp_q[i].d0) ||
                   wr1_q[b1+i].done !== exp_q[i].done || wr0_q[b0+i].done !== exp_q[i].done ||
                   wr1_q[b1+i].cyc != stamp_q[bs+i] || wr0_q[b0+i].cyc != stamp_q[bs+i]) begin
        bad++;
        if (first == "")
          first = $sformatf("entry %0d got addr %0d data %02h/%02h done %0b cyc %0d, want addr %0d data %02h/%02h done %0b cyc %0d",
                            i, wr1_q[b1+i].addr, wr1_q[b1+i].data, wr0_q[b0+i].data, wr1_q[b1+i].done,
                            wr1_q[b1+i].cyc, exp_q[i].addr, exp_q[i].d1, exp_q[i].d0, exp_q[i].done,
                            stamp_q[bs+i]);
      end
    end
    return bad;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sof = 1'b0; capture = 1'b0; pix_vld = 1'b0;
    end
  endtask

  task automatic pulse_capture();
    @(negedge clk); capture = 1'b1;
    @(negedge clk); capture = 1'b0;
  endtask

  // Streams rows y0..y1-1 of img, optionally preceded by sof and with
  // random idle gaps; records when each block-closing pixel is presented.
  task automatic drive_rows(input int y0, input int y1, input bit do_sof,
                            input bit gaps, input int cap_row);
    if (do_sof) begin
      @(negedge clk);
      sof = 1'b1; pix_vld = 1'b0; capture = 1'b0;
    end
    for (int yy = y0; yy < y1; yy++) begin
      for (int xx = 0; xx < W; xx++) begin
        if (gaps && $urandom_range(0, 5) == 0) begin
          @(negedge clk);
          sof = 1'b0; capture = 1'b0; pix_vld = 1'b0; pix_gray = 12'($urandom);
        end
        @(negedge clk);
        sof      = 1'b0;
        capture  = (yy == cap_row) && (xx == 7);
        pix_vld  = 1'b1;
        pix_gray = img[yy][xx];
        if (xx >= XS && xx < XS + WIN && yy >= YS && yy < YS + WIN &&
            (xx - XS) % 16 == 15 && (yy - YS) % 16 == 15)
          stamp_q.push_back(cyc + 1);
        if (xx == XS + 15 && yy == YS + 15) first_blk_cyc = cyc + 1;
      end
    end
    @(negedge clk);
    sof = 1'b0; capture = 1'b0; pix_vld = 1'b0;
  endtask

  task automatic fill_const(input logic [11:0] v);
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++) img[yy][xx] = v;
  endtask

  task automatic fill_random();
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++) img[yy][xx] = 12'($urandom);
  endtask

  // Full capture: request, a few ignored rows while armed, then the frame.
  task automatic capture_frame();
    pulse_capture();
    armed_busy = busy1;
    drive_rows(0, 3, 1'b0, 1'b0, -1);
    drive_rows(0, H, 1'b1, 1'b0, -1);
    idle(4);
    model_segment(H, 1'b1);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_assert++;
    if ({we1, waddr1, wdata1, busy1, done1, we0, waddr0, wdata0, busy0, done0} !== 42'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h/%h we %b%b busy %b%b done %b%b, want all 0",
               waddr1, wdata1, we1, we0, busy1, busy0, done1, done0);
    end
    @(negedge clk); rst_n = 1'b1;
    idle(3);
    n_assert++;
    if ({we1, busy1, done1, we0, busy0, done0} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_release_idle: we %b%b busy %b%b done %b%b, want 0", we1, we0, busy1, busy0, done1, done0);
    end
  endtask

  task automatic test_no_capture();
    int b1, b0, dc;
    b1 = wr1_q.size(); b0 = wr0_q.size(); dc = done1_cnt;
    fill_random();
    drive_rows(0, 34, 1'b1, 1'b0, -1);
    idle(4);
    n_assert++;
    if (wr1_q.size() != b1 || wr0_q.size() != b0) begin
      n_fail++;
      $display("FAIL no_capture_writes: got %0d/%0d writes, want 0", wr1_q.size() - b1, wr0_q.size() - b0);
    end
    n_assert++;
    if (busy1 !== 1'b0 || done1_cnt != dc) begin
      n_fail++;
      $display("FAIL no_capture_state: busy %b done pulses %0d, want 0 and 0", busy1, done1_cnt - dc);
    end
  endtask

  task automatic test_constant();
    int b1, b0, bs, dc1, dc0, be, bad;
    string first;
    b1 = wr1_q.size(); b0 = wr0_q.size(); bs = stamp_q.size();
    dc1 = done1_cnt; dc0 = done0_cnt; be = busy_err;
    exp_q.delete();
    fill_const(12'hFFF);
    capture_frame();
    n_assert++;
    if (armed_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL const_armed_busy: got %b, want 1", armed_busy);
    end
    n_assert++;
    if (wr1_q.size() - b1 != NW || wr0_q.size() - b0 != NW) begin
      n_fail++;
      $display("FAIL const_count: got %0d/%0d writes, want %0d", wr1_q.size() - b1, wr0_q.size() - b0, NW);
    end
    bad = score(b1, b0, bs, first);
    n_assert++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL const_data: %0d bad writes, %s", bad, first);
    end
    n_assert++;
    if (wr1_q.size() < b1 + NW || wr1_q[b1 + NW - 1].data !== 8'h00 || wr1_q[b1 + NW - 1].done !== 1'b1) begin
      n_fail++;
      $display("FAIL const_last_inverted: want data 00 with done on final write");
    end
    n_assert++;
    if (done1_cnt - dc1 != 1 || done0_cnt - dc0 != 1 || busy_err != be || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL const_done_busy: done %0d/%0d busy_err %0d busy %b, want 1/1 0 0",
               done1_cnt - dc1, done0_cnt - dc0, busy_err - be, busy1);
    end
  endtask

  task automatic test_midgray();
    int b1, b0, bs, bad;
    string first;
    b1 = wr1_q.size(); b0 = wr0_q.size(); bs = stamp_q.size();
    exp_q.delete();
    fill_const(12'h800);
    capture_frame();
    n_assert++;
    if (wr1_q.size() - b1 != NW || wr0_q.size() - b0 != NW) begin
      n_fail++;
      $display("FAIL mid_count: got %0d/%0d writes, want %0d", wr1_q.size() - b1, wr0_q.size() - b0, NW);
    end
    bad = score(b1, b0, bs, first);
    n_assert++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL mid_data: %0d bad writes, %s", bad, first);
    end
    n_assert++;
    if (wr1_q.size() <= b1 || wr0_q.size() <= b0 || wr1_q[b1].data !== 8'h7F || wr0_q[b0].data !== 8'h80) begin
      n_fail++;
      $display("FAIL mid_literal: first write not 7F (inverted) / 80 (plain)");
    end
  endtask

  task automatic test_checkerboard();
    int b1, b0, bs, bad;
    string first;
    b1 = wr1_q.size(); b0 = wr0_q.size(); bs = stamp_q.size();
    exp_q.delete();
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        if (xx >= XS && xx < XS + WIN && yy >= YS && yy < YS + WIN)
          img[yy][xx] = (((xx - XS) / 16 + (yy - YS) / 16) % 2 == 1) ? 12'hFF0 : 12'h000;
        else
          img[yy][xx] = 12'($urandom);
    capture_frame();
    bad = score(b1, b0, bs, first);
    n_assert++;
    if (bad != 0 || wr1_q.size() - b1 != NW) begin
      n_fail++;
      $display("FAIL checker_data: %0d bad writes of %0d, %s", bad, wr1_q.size() - b1, first);
    end
    n_assert++;
    if (wr0_q.size() < b0 + 2 || {wr0_q[b0].data, wr0_q[b0+1].data} !== 16'h00FF) begin
      n_fail++;
      $display("FAIL checker_literal: addresses 0,1 not 00,FF");
    end
    n_assert++;
    if (wr1_q.size() <= b1 || wr1_q[b1].cyc != first_blk_cyc) begin
      n_fail++;
      $display("FAIL checker_first_latency: first write cycle %0d, want %0d",
               (wr1_q.size() > b1) ? wr1_q[b1].cyc : -1, first_blk_cyc);
    end
  endtask

  task automatic test_restart();
    int b1, b0, bs, dc1, be, bad;
    string first;
    b1 = wr1_q.size(); b0 = wr0_q.size(); bs = stamp_q.size();
    dc1 = done1_cnt; be = busy_err;
    exp_q.delete();
    fill_random();
    pulse_capture();
    drive_rows(0, 34, 1'b1, 1'b0, -1);
    model_segment(34, 1'b0);
    fill_random();
    drive_rows(0, H, 1'b1, 1'b1, 20);
    idle(4);
    model_segment(H, 1'b1);
    n_assert++;
    if (wr1_q.size() - b1 != G + NW || wr0_q.size() - b0 != G + NW) begin
      n_fail++;
      $display("FAIL restart_count: got %0d/%0d writes, want %0d", wr1_q.size() - b1, wr0_q.size() - b0, G + NW);
    end
    bad = score(b1, b0, bs, first);
    n_assert++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL restart_data: %0d bad writes, %s", bad, first);
    end
    n_assert++;
    if (wr1_q.size() <= b1 + G || wr1_q[b1 + G].addr !== 10'd0) begin
      n_fail++;
      $display("FAIL restart_addr0: first write after restart not at address 0");
    end
    n_assert++;
    if (done1_cnt - dc1 != 1 || busy_err != be) begin
      n_fail++;
      $display("FAIL restart_done_busy: done %0d busy_err %0d, want 1 and 0", done1_cnt - dc1, busy_err - be);
    end
  endtask

  task automatic test_reset_mid();
    int b1, b0, bs, bad;
    string first;
    b1 = wr1_q.size(); b0 = wr0_q.size(); bs = stamp_q.size();
    exp_q.delete();
    fill_random();
    pulse_capture();
    drive_rows(0, 40, 1'b1, 1'b0, -1);
    model_segment(40, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_assert++;
    if ({we1, waddr1, wdata1, busy1, done1, we0, waddr0, wdata0, busy0, done0} !== 42'd0) begin
      n_fail++;
      $display("FAIL midreset_async: got %h/%h busy %b%b, want all 0", waddr1, wdata1, busy1, busy0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive_rows(40, 50, 1'b0, 1'b0, -1);
    drive_rows(0, 20, 1'b1, 1'b0, -1);
    idle(4);
    bad = score(b1, b0, bs, first);
    n_assert++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL midreset_pre_writes: %0d bad writes, %s", bad, first);
    end
    n_assert++;
    if (wr1_q.size() - b1 != G || wr0_q.size() - b0 != G) begin
      n_fail++;
      $display("FAIL midreset_count: got %0d/%0d writes, want %0d", wr1_q.size() - b1, wr0_q.size() - b0, G);
    end
    n_assert++;
    if (busy1 !== 1'b0 || busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_idle: busy %b%b, want 00", busy1, busy0);
    end
  endtask

  initial begin
    rst_n = 1'b0; capture = 1'b0; sof = 1'b0; pix_vld = 1'b0; pix_gray = '0;
    n_assert = 0; n_fail = 0; first_blk_cyc = -1; armed_busy = 1'b0;
    test_reset();
    test_no_capture();
    test_constant();
    test_midgray();
    test_checkerboard();
    test_restart();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/image_downsample.md
IMAGE_DOWNSAMPLE -- requirements
Module: image_downsample

Interface
REQ-001 Parameter FRAME_W, default 640, active pixels per camera line.
REQ-002 Parameter X_START, default 96, first frame column inside the 448x448 capture window.
REQ-003 Parameter Y_START, default 16, first frame row inside the 448x448 capture window.
REQ-004 Parameter INVERT, default 1: 1 = output 255-avg (dark ink becomes bright); 0 = output avg.
REQ-005 clk  input  1  system clock; all logic on posedge clk.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 capture  input  1  single-cycle request to grab the next frame.
REQ-008 sof  input  1  start-of-frame pulse, asserted one cycle before the first pixel of a frame.
REQ-009 pix_vld  input  1  pix_gray is valid this cycle; pixels arrive in raster order.
REQ-010 pix_gray  input  12  grayscale pixel; only bits [11:4] are used.
REQ-011 mem_we  output  1  write strobe to image_mem.
REQ-012 mem_waddr  output  10  image_mem address, 0..783, row-major 28x28.
REQ-013 mem_wdata  output  8  downsampled pixel value.
REQ-014 busy  output  1  high in ARMED and CAPTURE.
REQ-015 done  output  1  single-cycle pulse when the last pixel (address 783) has been written.

Function
REQ-016 FSM states: IDLE, ARMED, CAPTURE.
- IDLE -> ARMED on capture.
- ARMED -> CAPTURE on sof.
- CAPTURE -> IDLE after the write to address 783.
REQ-017 capture is ignored while busy=1.
REQ-018 A sof received in CAPTURE clears all counters and accumulators, sets mem_waddr to 0, and restarts capture of the new frame in CAPTURE; no done pulse is issued for the aborted frame.
REQ-019 Column counter x (0..FRAME_W-1):
- counts pix_vld;
- wraps to 0 after FRAME_W-1, and row counter y increments on that wrap;
- sof clears both counters.
REQ-020 A pixel is in-window when X_START<=x<X_START+448 and Y_START<=y<Y_START+448; pixels outside the window are ignored.
REQ-021 Block indices are bx=(x-X_START)/16 and by=(y-Y_START)/16. Sub-indices are sx=(x-X_START)%16 and sy=(y-Y_START)%16.
REQ-022 Accumulators: 28 unsigned 16-bit values acc[bx]; each in-window pixel adds pix_gray[11:4] to acc[bx].
REQ-023 Block completion and write:
- a block completes on its in-window pixel with sx=15 and sy=15;
- avg=(acc[bx]+pix8)>>8, with the sum in 16 bits (max 65280, no overflow);
- mem_wdata = INVERT ? 8'd255-avg : avg;
- acc[bx] is cleared on that same cycle.
REQ-024 Write timing:
- mem_we, mem_waddr and mem_wdata are registered;
- mem_we is high for exactly one cycle, starting the cycle after the completing pix_vld.
REQ-025 mem_waddr starts at 0 for each capture and increments by 1 after each write, giving order by*28+bx; it never exceeds 783.
REQ-026 done pulses on the same cycle as the mem_we for address 783; busy falls on the next cycle.
REQ-027 No writes occur in IDLE or ARMED; pix_vld is ignored in those states.
REQ-028 Throughput: one pixel per cycle with pix_vld continuously high; no back-pressure; at most one write per 16 in-window pixels.
REQ-029 After done, rows y>=Y_START+448 of the same frame are ignored.

Reset
REQ-030 While rst_n=0 the block is forced to: state IDLE; counters 0; all acc 0; mem_we=0; mem_waddr=0; mem_wdata=0; busy=0; done=0.
REQ-031 Reset asserted mid-capture abandons the frame with no further writes; the block stays in IDLE until the next capture.

Verification
REQ-032 Constant frame: capture, then sof, then a 640x480 frame of pix_gray=12'hFFF with INVERT=1 -> 784 writes at addresses 0..783, all mem_wdata=8'h00, and one done pulse coincident with address 783.
REQ-033 Mid-gray frame: pix_gray=12'h800 with INVERT=1 -> every mem_wdata=8'h7F; the same frame with INVERT=0 -> every mem_wdata=8'h80.
REQ-034 Checkerboard and timing:
- stimulus: in-window pixel = 12'hFF0 when (bx+by) is odd, else 12'h000;
- INVERT=0 -> address a = by*28+bx has wdata FF if odd, else 00;
- first mem_we occurs exactly 1 cycle after pixel (x=111, y=31).
REQ-035 Capture pulsed during CAPTURE is ignored (784 writes, busy unchanged); a second sof at frame row 200 restarts the capture, address 0 is rewritten, and done fires only at the end of the new frame.
REQ-036 Pixels before capture produce no writes; rst_n=0 asserted at frame row 300 -> outputs go to 0 immediately and there are no writes after release until a new capture and sof.
